// File: rtl/rv_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv_rf_pkg
// Purpose : Shared types and default sizes for the clearing 2R1W register file.
//           Holds the clear/run state enum and the default XLEN/DEPTH values
//           used by rv_rf_clr_seq and rv_rf_2r1w_clr.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package rv_rf_pkg;

  localparam int unsigned RF_XLEN_DEFAULT  = 32;
  localparam int unsigned RF_DEPTH_DEFAULT = 256;

  // CLEAR: array is being zeroed one entry per cycle, functional writes ignored.
  // RUN  : normal register-file operation.
  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

endpackage
`default_nettype wire

// File: rtl/rv_rf_clr_seq.sv
`default_nettype none
// ============================================================================
// Module  : rv_rf_clr_seq
// Purpose : Post-reset clear sequencer. Walks clr_ptr over every entry of the
//           register array (one per cycle) and then enters RUN for good,
//           raising rf_ready the cycle after the last entry is cleared.
// Ports   : clk          - clock, rising edge
//           rst          - synchronous active-high reset (restarts the clear)
//           clr_ptr_o    - entry being cleared this cycle (valid while !rf_ready_o)
//           rf_ready_o   - 1 once the clear has completed (registered)
// Revision: 1.0 - initial release
// ============================================================================
module rv_rf_clr_seq
  import rv_rf_pkg::*;
#(
  parameter  int unsigned DEPTH = RF_DEPTH_DEFAULT,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] clr_ptr_o,
  output logic          rf_ready_o
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          rf_ready_q, rf_ready_d;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == RF_CLEAR) begin
      // DEPTH is a power of two, so the increment on the last entry wraps to 0
      // in the same cycle the sequencer moves to RUN.
      clr_ptr_d = clr_ptr_q + AW'(1);
      if (clr_ptr_q == AW'(DEPTH - 1)) begin
        state_d = RF_RUN;
      end
    end
    // rf_ready is a registered copy of "state is RUN".
    rf_ready_d = (state_d == RF_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RF_CLEAR;
      clr_ptr_q  <= '0;
      rf_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rf_ready_q <= rf_ready_d;
    end
  end

  assign clr_ptr_o  = clr_ptr_q;
  assign rf_ready_o = rf_ready_q;

endmodule
`default_nettype wire

// File: rtl/rv_rf_2r1w_clr.sv
`default_nettype none
// ============================================================================
// Module  : rv_rf_2r1w_clr
// Purpose : XLEN x DEPTH register file, two registered read ports and one
//           write port, self-clearing after reset. Optional hardwired-zero
//           entry 0 and optional same-cycle write-to-read forwarding.
// Ports   : clk                      - clock, rising edge
//           rst                      - synchronous active-high reset
//           c_rf_wr                  - write strobe (ignored until rf_ready)
//           rd_addr / rd_dati        - write address / write data
//           rs1_en, rs2_en           - read capture enables (0 holds output)
//           rs1_addr, rs2_addr       - read addresses
//           rs1_dato_reg, rs2_dato_reg - registered read data (1-cycle latency)
//           rf_ready                 - 1 once the post-reset clear is complete
// Revision: 1.0 - initial release
// ============================================================================
module rv_rf_2r1w_clr
  import rv_rf_pkg::*;
#(
  parameter  int unsigned XLEN     = RF_XLEN_DEFAULT,
  parameter  int unsigned DEPTH    = RF_DEPTH_DEFAULT,
  parameter  bit          ZERO_REG = 1'b1,
  parameter  bit          BYPASS   = 1'b1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            c_rf_wr,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_dati,
  input  logic            rs1_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic            rs2_en,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_dato_reg,
  output logic [XLEN-1:0] rs2_dato_reg,
  output logic            rf_ready
);

  logic [AW-1:0] clr_ptr;
  logic          ready;

  rv_rf_clr_seq #(
    .DEPTH (DEPTH)
  ) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_ptr_o  (clr_ptr),
    .rf_ready_o (ready)
  );

  assign rf_ready = ready;

  // --------------------------------------------------------------------------
  // Single write port, muxed between the clear path and the functional path.
  // --------------------------------------------------------------------------
  logic            func_we;
  logic            clr_we;
  logic            arr_we;
  logic [AW-1:0]   arr_waddr;
  logic [XLEN-1:0] arr_wdata;

  // Functional write: only in RUN, never while reset is asserted, and a write
  // to the hardwired-zero entry is dropped. This same term defines a bypass hit.
  assign func_we   = ready && !rst && c_rf_wr && !(ZERO_REG && (rd_addr == '0));
  assign clr_we    = !ready && !rst;
  assign arr_we    = func_we || clr_we;
  assign arr_waddr = ready ? rd_addr : clr_ptr;
  assign arr_wdata = ready ? rd_dati : '0;

  logic [XLEN-1:0] rf_q [DEPTH];

  always_ff @(posedge clk) begin
    if (arr_we) begin
      rf_q[arr_waddr] <= arr_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports: identical, independent logic per port.
  // --------------------------------------------------------------------------
  logic [1:0]         rs_en;
  logic [1:0][AW-1:0] rs_addr;

  assign rs_en   = {rs2_en, rs1_en};
  assign rs_addr = {rs2_addr, rs1_addr};

  for (genvar p = 0; p < 2; p++) begin : g_rport
    logic [XLEN-1:0] dat_d;
    logic [XLEN-1:0] dat_q;

    always_comb begin
      dat_d = rf_q[rs_addr[p]];
      if (!ready || (ZERO_REG && (rs_addr[p] == '0))) begin
        // During the clear the array is only partly zeroed; present 0.
        dat_d = '0;
      end else if (BYPASS && func_we && (rd_addr == rs_addr[p])) begin
        dat_d = rd_dati;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dat_q <= '0;
      end else if (rs_en[p]) begin
        dat_q <= dat_d;
      end
    end
  end

  assign rs1_dato_reg = g_rport[0].dat_q;
  assign rs2_dato_reg = g_rport[1].dat_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_rf_2r1w_clr.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv_rf_2r1w_clr
// Purpose : Self-checking bench for rv_rf_2r1w_clr. Two instances share one
//           stimulus stream: A (DEPTH 256, ZERO_REG 1, BYPASS 1) and
//           B (DEPTH 16, ZERO_REG 0, BYPASS 0, low address bits only).
//           A behavioural model tracks both and is compared every cycle;
//           directed scenarios add literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv_rf_2r1w_clr;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        c_rf_wr;
  logic [7:0]  rd_addr;
  logic [31:0] rd_dati;
  logic        rs1_en, rs2_en;
  logic [7:0]  rs1_addr, rs2_addr;

  logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2;
  logic        a_rdy, b_rdy;

  rv_rf_2r1w_clr #(
    .XLEN(32), .DEPTH(256), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .c_rf_wr(c_rf_wr), .rd_addr(rd_addr), .rd_dati(rd_dati),
    .rs1_en(rs1_en), .rs1_addr(rs1_addr), .rs2_en(rs2_en), .rs2_addr(rs2_addr),
    .rs1_dato_reg(a_rs1), .rs2_dato_reg(a_rs2), .rf_ready(a_rdy)
  );

  rv_rf_2r1w_clr #(
    .XLEN(32), .DEPTH(16), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .c_rf_wr(c_rf_wr), .rd_addr(rd_addr[3:0]), .rd_dati(rd_dati),
    .rs1_en(rs1_en), .rs1_addr(rs1_addr[3:0]), .rs2_en(rs2_en), .rs2_addr(rs2_addr[3:0]),
    .rs1_dato_reg(b_rs1), .rs2_dato_reg(b_rs2), .rf_ready(b_rdy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: ready after DEPTH non-reset cycles; before that reads
  // give 0 and writes are ignored. Afterwards a plain array with the zero-reg
  // and forwarding rules applied to the value a read captures.
  // --------------------------------------------------------------------------
  logic [31:0] mem [2][256];
  logic [31:0] m_rs1 [2];
  logic [31:0] m_rs2 [2];
  int          cnt [2];
  bit          mvalid = 1'b0;

  function automatic int dep(input int k);
    return (k == 0) ? 256 : 16;
  endfunction

  function automatic bit zr(input int k);
    return (k == 0);
  endfunction

  function automatic bit byp(input int k);
    return (k == 0);
  endfunction

  function automatic logic [31:0] pick(input int k, input int a, input bit rdy,
                                       input bit wr, input int wa);
    if (!rdy || (zr(k) && a == 0)) return 32'h0;
    if (byp(k) && wr && wa == a) return rd_dati;
    return mem[k][a];
  endfunction

  always @(posedge clk) begin
    int wa, a1, a2;
    bit rdy, wr;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cnt[k]   = 0;
        m_rs1[k] = 32'h0;
        m_rs2[k] = 32'h0;
        for (int i = 0; i < 256; i++) mem[k][i] = 32'h0;
      end else begin
        rdy = (cnt[k] >= dep(k));
        wa  = int'(rd_addr) % dep(k);
        a1  = int'(rs1_addr) % dep(k);
        a2  = int'(rs2_addr) % dep(k);
        wr  = rdy && c_rf_wr && !(zr(k) && wa == 0);
        if (rs1_en) m_rs1[k] = pick(k, a1, rdy, wr, wa);
        if (rs2_en) m_rs2[k] = pick(k, a2, rdy, wr, wa);
        if (wr) mem[k][wa] = rd_dati;
        if (!rdy) cnt[k]++;
      end
    end
    if (rst) mvalid = 1'b1;
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (mvalid) begin
      check("a_ready", {31'b0, a_rdy}, {31'b0, (cnt[0] >= 256)});
      check("a_rs1",   a_rs1, m_rs1[0]);
      check("a_rs2",   a_rs2, m_rs2[0]);
      check("b_ready", {31'b0, b_rdy}, {31'b0, (cnt[1] >= 16)});
      check("b_rs1",   b_rs1, m_rs1[1]);
      check("b_rs2",   b_rs2, m_rs2[1]);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (a_rdy !== 1'b1 && n < 400) begin
      step(1);
      n++;
    end
  endtask

  task automatic idle();
    c_rf_wr = 1'b0;
    rs1_en  = 1'b0;
    rs2_en  = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; c_rf_wr = 1'b0; rd_addr = 8'd0; rd_dati = 32'h0;
    rs1_en = 1'b0; rs2_en = 1'b0; rs1_addr = 8'd0; rs2_addr = 8'd0;
    step(2);
    check("reset_ready", {31'b0, a_rdy}, 32'h0);
    check("reset_rs1",   a_rs1, 32'h0);
    check("reset_rs2",   a_rs2, 32'h0);

    // Clear timing, with a write to entry 3 attempted throughout the clear.
    rst = 1'b0;
    c_rf_wr = 1'b1; rd_addr = 8'd3; rd_dati = 32'hA5A5_5A5A;
    rs1_en = 1'b1; rs1_addr = 8'd3;
    wait_ready(n);
    check("clear_cycles", n, 32'd256);
    check("clear_read_zero", a_rs1, 32'h0);
    c_rf_wr = 1'b0;
    rs2_en = 1'b1; rs2_addr = 8'd255;
    step(1);
    check("ignored_clear_write", a_rs1, 32'h0);
    check("cleared_entry_255",   a_rs2, 32'h0);

    // Basic write then read.
    idle();
    c_rf_wr = 1'b1; rd_addr = 8'd5; rd_dati = 32'hDEAD_BEEF;
    step(1);
    c_rf_wr = 1'b0; rs1_en = 1'b1; rs1_addr = 8'd5;
    step(1);
    check("basic_rd_a", a_rs1, 32'hDEAD_BEEF);
    check("basic_rd_b", b_rs1, 32'hDEAD_BEEF);

    // Same-cycle write/read on port 2.
    idle();
    c_rf_wr = 1'b1; rd_addr = 8'd7; rd_dati = 32'h1234_5678;
    rs2_en = 1'b1; rs2_addr = 8'd7;
    step(1);
    check("bypass_a", a_rs2, 32'h1234_5678);
    check("nobypass_b_old", b_rs2, 32'h0);
    c_rf_wr = 1'b0;
    step(1);
    check("nobypass_b_after", b_rs2, 32'h1234_5678);

    // Entry 0 behaviour.
    idle();
    c_rf_wr = 1'b1; rd_addr = 8'd0; rd_dati = 32'hFFFF_FFFF;
    step(1);
    c_rf_wr = 1'b0; rs1_en = 1'b1; rs2_en = 1'b1; rs1_addr = 8'd0; rs2_addr = 8'd0;
    step(1);
    check("zero_a_rs1", a_rs1, 32'h0);
    check("zero_a_rs2", a_rs2, 32'h0);
    check("zero_b_rs1", b_rs1, 32'hFFFF_FFFF);
    check("zero_b_rs2", b_rs2, 32'hFFFF_FFFF);

    // Hold with rs1_en low while the address changes.
    idle();
    rs1_en = 1'b1; rs1_addr = 8'd5;
    step(1);
    rs1_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rs1_addr = 8'(7 + i * 60);
      step(1);
      check("hold_rs1", a_rs1, 32'hDEAD_BEEF);
    end

    // Randomized traffic, addresses mostly in a small window to force hits.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 999) == 0);
      c_rf_wr  = $urandom_range(0, 1);
      rd_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      rd_dati  = $urandom;
      rs1_en   = ($urandom_range(0, 3) != 0);
      rs2_en   = ($urandom_range(0, 3) != 0);
      rs1_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      rs2_addr = ($urandom_range(0, 1) == 0) ? rs1_addr : 8'($urandom_range(0, 15));
      step(1);
    end
    rst = 1'b0;
    idle();
    wait_ready(n);

    // Reset after writes in RUN, and again in the middle of the clear.
    c_rf_wr = 1'b1; rd_addr = 8'd5; rd_dati = 32'hCAFE_F00D;
    step(1);
    rd_addr = 8'd200; rd_dati = 32'h1111_2222;
    step(1);
    c_rf_wr = 1'b0; rst = 1'b1;
    step(1);
    check("rst_drops_ready", {31'b0, a_rdy}, 32'h0);
    rst = 1'b0;
    step(100);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wait_ready(n);
    check("reclear_cycles", n, 32'd256);
    rs1_en = 1'b1; rs1_addr = 8'd5; rs2_en = 1'b1; rs2_addr = 8'd200;
    step(1);
    check("reclear_rd5",   a_rs1, 32'h0);
    check("reclear_rd200", a_rs2, 32'h0);
    idle();
    step(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/rv_rf_2r1w_clr.md
RV_RF_2R1W_CLR -- requirements
Module: rv_rf_2r1w_clr

Interface
REQ-001 Parameter XLEN, 32, data width of each entry.
REQ-002 Parameter DEPTH, 256, number of entries; power of two, >= 2.
REQ-003 Parameter ZERO_REG, 1, entry 0 hardwired to zero when 1.
REQ-004 Parameter BYPASS, 1, same-cycle write-to-read forwarding when 1.
REQ-005 Derived constant AW = $clog2(DEPTH), width of every address port.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset; synchronous, active-high.
REQ-008 c_rf_wr  input  1  write strobe.
REQ-009 rd_addr  input  AW  write address.
REQ-010 rd_dati  input  XLEN  write data.
REQ-011 rs1_en, rs2_en  input  1 each  read-port capture enables; 0 holds the port output.
REQ-012 rs1_addr, rs2_addr  input  AW each  read addresses.
REQ-013 rs1_dato_reg, rs2_dato_reg  output  XLEN each  registered read data.
REQ-014 rf_ready  output  1  high when the clear sequence is done and writes are accepted.

Function
REQ-015 The block SHALL run a two-state FSM: CLEAR and RUN.
REQ-016 In CLEAR, each cycle SHALL write 0 to rf[clr_ptr] and increment clr_ptr.
REQ-017 The FSM SHALL leave CLEAR after the cycle that clears DEPTH-1. rf_ready SHALL be 1 from the next cycle onward. Total: exactly DEPTH cycles after rst deasserts.
REQ-018 In CLEAR, c_rf_wr SHALL be ignored: no write, no bypass. Reads with rsN_en=1 SHALL capture 0.
REQ-019 In RUN, c_rf_wr=1 SHALL write rd_dati to rf[rd_addr] at the clock edge. When ZERO_REG=1 and rd_addr=0, the write SHALL be discarded.
REQ-020 Read latency SHALL be 1 cycle. When rsN_en=1 at an edge, rsN_dato_reg SHALL take the selected value. When rsN_en=0, it SHALL hold its previous value.
REQ-021 For read address 0 with ZERO_REG=1, the selected value SHALL be 0.
REQ-022 For a same-cycle write/read hit with BYPASS=1, the selected value SHALL be rd_dati. A hit means RUN, c_rf_wr=1 and rd_addr=rsN_addr, excluding address 0 when ZERO_REG=1.
REQ-023 For a same-cycle hit with BYPASS=0, the selected value SHALL be the old array content.
REQ-024 Otherwise, the selected value SHALL be rf[rsN_addr].
REQ-025 Both read ports SHALL operate independently. Identical addresses on both ports SHALL return identical data.
REQ-026 clr_ptr SHALL be AW bits wide. Its wrap from DEPTH-1 to 0 SHALL coincide with the transition to RUN; clr_ptr is unused in RUN.

Reset
REQ-027 rst=1 at an edge SHALL force: FSM to CLEAR, clr_ptr=0, rf_ready=0, rs1_dato_reg=0, rs2_dato_reg=0.
REQ-028 rst asserted mid-CLEAR or mid-RUN SHALL restart the clear sequence from entry 0. Array contents are undefined until that sequence completes.
REQ-029 While rst=1, c_rf_wr SHALL have no effect.

Structure
REQ-030 Package rv_rf_pkg SHALL hold the FSM state enum (RF_CLEAR, RF_RUN) and the default XLEN/DEPTH constants.
REQ-031 The array SHALL be a single XLEN x DEPTH register array with one write port.
REQ-032 The write port SHALL be muxed between the clear path and the functional path.
REQ-033 The FSM, clr_ptr and rf_ready SHALL live in one sub-module, rv_rf_clr_seq. The array and read/bypass logic SHALL stay in the top.

Verification
REQ-034 Clear timing, DEPTH=256: rst high 2 cycles then low -> rf_ready=0 for 256 cycles, then 1; a read of any address afterwards returns 0.
REQ-035 Basic write/read: write 0xDEADBEEF to address 5; next cycle rs1_addr=5, rs1_en=1 -> rs1_dato_reg=0xDEADBEEF one cycle later.
REQ-036 Bypass: same cycle c_rf_wr=1, rd_addr=7, rd_dati=0x12345678, rs2_addr=7 -> rs2_dato_reg=0x12345678 next cycle with BYPASS=1; 0 (old value) with BYPASS=0.
REQ-037 Zero register: write 0xFFFFFFFF to address 0, then read address 0 on both ports -> 0 when ZERO_REG=1; 0xFFFFFFFF when ZERO_REG=0.
REQ-038 Hold and ignore: rs1_en=0 with a changing rs1_addr -> rs1_dato_reg unchanged; c_rf_wr=1 to address 3 during CLEAR -> address 3 reads 0 after rf_ready.
REQ-039 Reset mid-operation: rst pulsed at clear cycle 100, and again after writes in RUN -> rf_ready drops, returns after 256 cycles, and all previously written entries read 0.
